// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-set path: FSM state encoding,
// display field-select codes and the BCD limits used when editing HH:MM.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } set_state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HOUR = 2'b01;
    localparam logic [1:0] FIELD_MIN  = 2'b10;

    localparam logic [3:0] HOUR_WRAP_TENS = 4'd2;
    localparam logic [3:0] HOUR_WRAP_ONES = 4'd3;
    localparam logic [3:0] MIN_MAX_TENS   = 4'd5;
    localparam logic [3:0] BCD_MAX        = 4'd9;

    // True when tens:ones is a legal BCD hour 00..23.
    function automatic logic hour_in_range(input logic [3:0] tens, input logic [3:0] ones);
        return (ones <= BCD_MAX) &&
               ((tens < HOUR_WRAP_TENS) ||
                ((tens == HOUR_WRAP_TENS) && (ones <= HOUR_WRAP_ONES)));
    endfunction

    // True when tens:ones is a legal BCD minute 00..59.
    function automatic logic min_in_range(input logic [3:0] tens, input logic [3:0] ones);
        return (ones <= BCD_MAX) && (tens <= MIN_MAX_TENS);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Purpose: synchronise an active-low raw button, debounce it, and emit a
//          one-cycle pulse on each debounced press (release gives no pulse).
// Latency: a raw edge held stable yields the press pulse DEBOUNCE_CYCLES+2 cycles later.
// Backpressure: none; the press pulse is fire-and-forget.
// Ports: clk, rst (async, active-high), btn_n (raw, active-low),
//        level (debounced pressed level), press (one-cycle press pulse).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // Inverted on entry so everything downstream is "pressed = 1".
            sync1 <= ~btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // This is the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Purpose: MODE/INC button front end and set-time FSM; captures running HH:MM,
//          edits hours then minutes in BCD, and commits with a one-cycle load.
// Latency: FSM/edit registers update on the edge after a debounced press pulse.
// Backpressure: none; counters must accept load whenever it is asserted.
// Ports: clk, rst (async, active-high), btn_mode_n/btn_inc_n (raw, active-low),
//        cur_* (running BCD time), set_active, field_sel, hour_*/min_* (edit
//        registers), load (commit strobe).
// Build option: define TIME_SET_AUTO_REPEAT_EN to auto-repeat INC every
//        REPEAT_CYCLES while held in an edit state; otherwise one step per press.
module time_set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic [3:0] cur_hour_tens,
    input  logic [3:0] cur_hour_ones,
    input  logic [3:0] cur_min_tens,
    input  logic [3:0] cur_min_ones,
    output logic       set_active,
    output logic [1:0] field_sel,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic       load
);

    set_state_t state_q, state_d;
    logic [3:0] hour_tens_q, hour_ones_q, min_tens_q, min_ones_q;
    logic [3:0] hour_tens_d, hour_ones_d, min_tens_d, min_ones_d;

    logic mode_press, mode_held_unused;
    logic inc_press, inc_level;
    logic rep_evt;
    logic inc_evt;
    logic editing;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_mode_n),
        .level (mode_held_unused),
        .press (mode_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk   (clk),
        .rst   (rst),
        .btn_n (btn_inc_n),
        .level (inc_level),
        .press (inc_press)
    );

    assign editing = (state_q == SET_HOUR) || (state_q == SET_MIN);

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int RCW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RCW-1:0] REP_LAST = RCW'(REPEAT_CYCLES - 1);
    localparam logic [RCW-1:0] REP_ONE  = RCW'(1);

    logic [RCW-1:0] rep_cnt;

    // In an edit state a MODE press always changes state, so it doubles as
    // the "state change" clear without looking at the next-state logic.
    assign rep_evt = inc_level && editing && !mode_press && (rep_cnt == REP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if (!inc_level || !editing || mode_press) begin
            rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + REP_ONE;
        end
    end
`else
    logic repeat_unused;

    // Held level and repeat period have no consumer without auto-repeat.
    assign repeat_unused = inc_level & (REPEAT_CYCLES > 0);
    assign rep_evt       = 1'b0;
`endif

    assign inc_evt = inc_press | rep_evt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hour_tens_q <= 4'd0;
            hour_ones_q <= 4'd0;
            min_tens_q  <= 4'd0;
            min_ones_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            hour_tens_q <= hour_tens_d;
            hour_ones_q <= hour_ones_d;
            min_tens_q  <= min_tens_d;
            min_ones_q  <= min_ones_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hour_tens_d = hour_tens_q;
        hour_ones_d = hour_ones_q;
        min_tens_d  = min_tens_q;
        min_ones_d  = min_ones_q;
        set_active  = 1'b0;
        field_sel   = FIELD_NONE;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (mode_press) begin
                    state_d = SET_HOUR;
                    // Garbage on the running-time bus is replaced by 00.
                    if (hour_in_range(cur_hour_tens, cur_hour_ones)) begin
                        hour_tens_d = cur_hour_tens;
                        hour_ones_d = cur_hour_ones;
                    end else begin
                        hour_tens_d = 4'd0;
                        hour_ones_d = 4'd0;
                    end
                    if (min_in_range(cur_min_tens, cur_min_ones)) begin
                        min_tens_d = cur_min_tens;
                        min_ones_d = cur_min_ones;
                    end else begin
                        min_tens_d = 4'd0;
                        min_ones_d = 4'd0;
                    end
                end
            end

            SET_HOUR: begin
                set_active = 1'b1;
                field_sel  = FIELD_HOUR;
                // MODE takes priority; a coincident INC is dropped.
                if (mode_press) begin
                    state_d = SET_MIN;
                end else if (inc_evt) begin
                    if ((hour_tens_q == HOUR_WRAP_TENS) && (hour_ones_q == HOUR_WRAP_ONES)) begin
                        hour_tens_d = 4'd0;
                        hour_ones_d = 4'd0;
                    end else if (hour_ones_q >= BCD_MAX) begin
                        hour_tens_d = hour_tens_q + 4'd1;
                        hour_ones_d = 4'd0;
                    end else begin
                        hour_ones_d = hour_ones_q + 4'd1;
                    end
                end
            end

            SET_MIN: begin
                set_active = 1'b1;
                field_sel  = FIELD_MIN;
                if (mode_press) begin
                    state_d = COMMIT;
                end else if (inc_evt) begin
                    // Minute wrap never carries into hours.
                    if (min_ones_q >= BCD_MAX) begin
                        min_ones_d = 4'd0;
                        min_tens_d = (min_tens_q >= MIN_MAX_TENS) ? 4'd0 : (min_tens_q + 4'd1);
                    end else begin
                        min_ones_d = min_ones_q + 4'd1;
                    end
                end
            end

            COMMIT: begin
                load    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign hour_tens = hour_tens_q;
    assign hour_ones = hour_ones_q;
    assign min_tens  = min_tens_q;
    assign min_ones  = min_ones_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Purpose: randomized plus directed bench for time_set_controller with a
//          scoreboard of expected commits checked by an independent load monitor.
// Latency/backpressure: presses are held long enough for press and release debounce.
module tb_time_set_controller;

    localparam int DEB  = 4;
    localparam int REP  = 10;
    localparam int HOLD = DEB + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode_n, btn_inc_n;
    logic [3:0] cur_hour_tens, cur_hour_ones, cur_min_tens, cur_min_ones;
    logic       set_active;
    logic [1:0] field_sel;
    logic [3:0] hour_tens, hour_ones, min_tens, min_ones;
    logic       load;

    always #5 clk = ~clk;

    time_set_controller #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_mode_n    (btn_mode_n),
        .btn_inc_n     (btn_inc_n),
        .cur_hour_tens (cur_hour_tens),
        .cur_hour_ones (cur_hour_ones),
        .cur_min_tens  (cur_min_tens),
        .cur_min_ones  (cur_min_ones),
        .set_active    (set_active),
        .field_sel     (field_sel),
        .hour_tens     (hour_tens),
        .hour_ones     (hour_ones),
        .min_tens      (min_tens),
        .min_ones      (min_ones),
        .load          (load)
    );

    typedef struct {
        int h;
        int m;
    } commit_t;

    commit_t exp_q[$];
    int      n_tests = 0;
    int      n_fail  = 0;

    // Reference model: 0 idle, 1 editing hours, 2 editing minutes.
    int m_state = 0;
    int m_h     = 0;
    int m_m     = 0;

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_mode();
        int h, m;
        case (m_state)
            0: begin
                h = int'(cur_hour_tens) * 10 + int'(cur_hour_ones);
                m = int'(cur_min_tens) * 10 + int'(cur_min_ones);
                m_h = (cur_hour_ones > 9 || h > 23) ? 0 : h;
                m_m = (cur_min_ones > 9 || m > 59) ? 0 : m;
                m_state = 1;
            end
            1: m_state = 2;
            default: begin
                commit_t c;
                c.h = m_h;
                c.m = m_m;
                exp_q.push_back(c);
                m_state = 0;
            end
        endcase
    endtask

    task automatic mdl_inc();
        if (m_state == 1) m_h = (m_h + 1) % 24;
        else if (m_state == 2) m_m = (m_m + 1) % 60;
    endtask

    task automatic check_live(input string tag);
        check({tag, "_set_active"}, int'(set_active), (m_state != 0) ? 1 : 0);
        check({tag, "_field_sel"}, int'(field_sel), m_state);
        if (m_state != 0) begin
            check({tag, "_hour"}, int'({hour_tens, hour_ones}), bcd(m_h));
            check({tag, "_min"}, int'({min_tens, min_ones}), bcd(m_m));
        end
    endtask

    task automatic press_mode();
        mdl_mode();
        btn_mode_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        btn_mode_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_live("mode");
    endtask

    task automatic press_inc();
        mdl_inc();
        btn_inc_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        btn_inc_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_live("inc");
    endtask

    task automatic set_cur(input int h, input int m);
        cur_hour_tens = 4'(h / 10);
        cur_hour_ones = 4'(h % 10);
        cur_min_tens  = 4'(m / 10);
        cur_min_ones  = 4'(m % 10);
    endtask

    // Load monitor: every strobe must match the oldest expected commit.
    initial begin
        bit prev_load = 1'b0;
        forever begin
            @(negedge clk);
            if (load) begin
                check("load_one_cycle", int'(prev_load), 0);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_load: got %0h%0h:%0h%0h with no commit expected at %0t",
                             hour_tens, hour_ones, min_tens, min_ones, $time);
                end else begin
                    commit_t e;
                    e = exp_q.pop_front();
                    check("commit_hour", int'({hour_tens, hour_ones}), bcd(e.h));
                    check("commit_min", int'({min_tens, min_ones}), bcd(e.m));
                    check("commit_set_active", int'(set_active), 0);
                end
            end
            prev_load = load;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete within cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        set_cur(0, 0);
        repeat (3) @(negedge clk);
        check("reset_set_active", int'(set_active), 0);
        check("reset_field_sel", int'(field_sel), 0);
        check("reset_load", int'(load), 0);
        check("reset_digits", int'({hour_tens, hour_ones, min_tens, min_ones}), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Capture and commit unchanged time.
        set_cur(14, 37);
        press_mode();
        press_mode();
        press_mode();
        check_live("after_commit");

        // Bounce rejection then a single clean press.
        set_cur(3, 20);
        press_mode();
        for (int i = 0; i < 10; i++) begin
            btn_inc_n = ~btn_inc_n;
            repeat (2) @(negedge clk);
        end
        btn_inc_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_live("bounce");
        mdl_inc();
        btn_inc_n = 1'b0;
        repeat (6) @(negedge clk);
        btn_inc_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_live("stable6");
        press_mode();
        press_mode();

        // Hour wrap 22 -> 23 -> 00 -> 01 ...
        set_cur(22, 5);
        press_mode();
        for (int i = 0; i < 5; i++) press_inc();
        press_mode();
        press_mode();

        // Minute wrap without hour carry, then hour BCD carry 09 -> 10.
        set_cur(8, 58);
        press_mode();
        press_mode();
        press_inc();
        press_inc();
        press_mode();
        set_cur(9, 41);
        press_mode();
        press_inc();
        press_mode();
        press_mode();

        // Out-of-range capture becomes 00:00; INC while idle is ignored.
        cur_hour_tens = 4'd2; cur_hour_ones = 4'd4;
        cur_min_tens  = 4'd6; cur_min_ones  = 4'd1;
        press_inc();
        press_mode();
        press_mode();
        press_mode();

        // Simultaneous MODE and INC: MODE wins; then reset mid-edit.
        set_cur(11, 11);
        press_mode();
        mdl_mode();
        btn_mode_n = 1'b0;
        btn_inc_n  = 1'b0;
        repeat (HOLD) @(negedge clk);
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        repeat (HOLD) @(negedge clk);
        check_live("simultaneous");
        rst = 1'b1;
        #1;
        m_state = 0;
        check("rst_set_active", int'(set_active), 0);
        check("rst_field_sel", int'(field_sel), 0);
        check("rst_load", int'(load), 0);
        check("rst_digits", int'({hour_tens, hour_ones, min_tens, min_ones}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Long INC hold in SET_MIN from 00.
        set_cur(13, 0);
        press_mode();
        press_mode();
        mdl_inc();
`ifdef TIME_SET_AUTO_REPEAT_EN
        mdl_inc();
        mdl_inc();
        mdl_inc();
`endif
        btn_inc_n = 1'b0;
        repeat (DEB + 2 + 32) @(negedge clk);
        btn_inc_n = 1'b1;
        repeat (HOLD + 2) @(negedge clk);
        check_live("long_hold");
        press_mode();

        // Randomized edit sessions.
        for (int s = 0; s < 25; s++) begin
            cur_hour_tens = 4'($urandom_range(0, 3));
            cur_hour_ones = 4'($urandom_range(0, 11));
            cur_min_tens  = 4'($urandom_range(0, 7));
            cur_min_ones  = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) press_inc();
            press_mode();
            cur_hour_tens = 4'($urandom_range(0, 2));
            for (int k = $urandom_range(0, 5); k > 0; k--) press_inc();
            press_mode();
            for (int k = $urandom_range(0, 5); k > 0; k--) press_inc();
            press_mode();
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
